// File: rtl/raster_sched.sv
// raster_sched: queues triangle commands and hands them one at a time to a rasterizer.
// Each triangle passes through a degenerate-cull check, a start pulse, and a watchdog-guarded wait.
module raster_sched #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1048576
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_tri_valid,
    output logic         o_tri_ready,
    input  logic [191:0] i_tri_xy,
    input  logic         i_cfg_we,
    input  logic [25:0]  i_cfg_base,
    output logic [191:0] o_rast_xy,
    output logic [25:0]  o_rast_base,
    output logic         o_rast_start,
    input  logic         i_rast_done,
    output logic         o_busy,
    output logic         o_timeout_err,
    output logic [15:0]  o_tri_drawn,
    output logic [15:0]  o_tri_culled
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int WW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    // Last RUN cycle before giving up: the watchdog would reach TIMEOUT-1 on this edge.
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_START = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [191:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic [25:0]   r_shadow_base;
    logic [191:0]  r_rast_xy;
    logic [25:0]   r_rast_base;
    logic [WW-1:0] r_wd;
    logic          r_timeout_err;
    logic [15:0]   r_drawn;
    logic [15:0]   r_culled;

    logic          w_push;
    logic          w_pop;
    logic          w_not_empty;
    logic          w_degen;
    logic          w_cull;
    logic          w_draw;
    logic          w_expire;
    logic          w_wd_clr;
    logic [31:0]   w_x1, w_y1, w_x2, w_y2, w_x3, w_y3;

    assign w_not_empty = (r_count != '0);
    assign o_tri_ready = (r_count != FULL_CNT);
    assign w_push      = i_tri_valid & o_tri_ready;

    assign {w_x1, w_y1, w_x2, w_y2, w_x3, w_y3} = r_rast_xy;
    assign w_degen = ((w_x1 == w_x2) && (w_x2 == w_x3)) ||
                     ((w_y1 == w_y2) && (w_y2 == w_y3));

    // Storage carries no reset; emptiness is defined by the pointers and count alone.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_tri_xy;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_not_empty) w_state_next = S_CHECK;
            S_CHECK: w_state_next = w_degen ? S_IDLE : S_START;
            S_START: w_state_next = S_RUN;
            S_RUN:   if (i_rast_done || (r_wd == WD_LAST)) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // rast_done only matters in RUN and takes priority over the watchdog expiring.
    always_comb begin
        w_pop        = 1'b0;
        w_cull       = 1'b0;
        o_rast_start = 1'b0;
        w_wd_clr     = 1'b0;
        w_draw       = 1'b0;
        w_expire     = 1'b0;
        case (r_state)
            S_IDLE:  w_pop = w_not_empty;
            S_CHECK: w_cull = w_degen;
            S_START: begin
                o_rast_start = 1'b1;
                w_wd_clr     = 1'b1;
            end
            S_RUN: begin
                w_draw   = i_rast_done;
                w_expire = !i_rast_done && (r_wd == WD_LAST);
            end
            default: ;
        endcase
    end

    assign o_busy = (r_state != S_IDLE) | w_not_empty;

    // Base is sampled from the shadow only when a triangle is popped.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shadow_base <= '0;
            r_rast_xy     <= '0;
            r_rast_base   <= '0;
        end else begin
            if (i_cfg_we) begin
                r_shadow_base <= i_cfg_base;
            end
            if (w_pop) begin
                r_rast_xy   <= r_mem[r_rd_ptr];
                r_rast_base <= r_shadow_base;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wd          <= '0;
            r_timeout_err <= 1'b0;
            r_drawn       <= '0;
            r_culled      <= '0;
        end else begin
            if (w_wd_clr) begin
                r_wd <= '0;
            end else if (r_state == S_RUN) begin
                r_wd <= r_wd + WW'(1);
            end
            if (w_expire) begin
                r_timeout_err <= 1'b1;
            end
            if (w_draw) begin
                r_drawn <= r_drawn + 16'd1;
            end
            if (w_cull) begin
                r_culled <= r_culled + 16'd1;
            end
        end
    end

    assign o_rast_xy     = r_rast_xy;
    assign o_rast_base   = r_rast_base;
    assign o_timeout_err = r_timeout_err;
    assign o_tri_drawn   = r_drawn;
    assign o_tri_culled  = r_culled;

endmodule

// File: tb/tb_raster_sched.sv
// Scoreboard bench for raster_sched: expected (vertices, base) pairs are queued on acceptance
// and popped when rast_start fires; per-feature tasks check counters, flags and timing.
module tb_raster_sched;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic         tri_valid, tri_ready, cfg_we, rast_start, rast_done, busy, timeout_err;
    logic [191:0] tri_xy, rast_xy;
    logic [25:0]  cfg_base, rast_base;
    logic [15:0]  tri_drawn, tri_culled;

    logic         t_tri_valid, t_tri_ready, t_cfg_we, t_rast_start, t_rast_done, t_busy, t_timeout_err;
    logic [191:0] t_tri_xy, t_rast_xy;
    logic [25:0]  t_cfg_base, t_rast_base;
    logic [15:0]  t_tri_drawn, t_tri_culled;

    raster_sched #(.DEPTH(4)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_tri_valid(tri_valid), .o_tri_ready(tri_ready), .i_tri_xy(tri_xy),
        .i_cfg_we(cfg_we), .i_cfg_base(cfg_base),
        .o_rast_xy(rast_xy), .o_rast_base(rast_base), .o_rast_start(rast_start),
        .i_rast_done(rast_done), .o_busy(busy), .o_timeout_err(timeout_err),
        .o_tri_drawn(tri_drawn), .o_tri_culled(tri_culled)
    );

    raster_sched #(.DEPTH(4), .TIMEOUT(16)) u_to (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_tri_valid(t_tri_valid), .o_tri_ready(t_tri_ready), .i_tri_xy(t_tri_xy),
        .i_cfg_we(t_cfg_we), .i_cfg_base(t_cfg_base),
        .o_rast_xy(t_rast_xy), .o_rast_base(t_rast_base), .o_rast_start(t_rast_start),
        .i_rast_done(t_rast_done), .o_busy(t_busy), .o_timeout_err(t_timeout_err),
        .o_tri_drawn(t_tri_drawn), .o_tri_culled(t_tri_culled)
    );

    typedef struct packed {
        logic [191:0] xy;
        logic [25:0]  base;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        t_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [25:0] m_base;

    function automatic logic [191:0] mk(input logic [31:0] x1, input logic [31:0] y1,
                                        input logic [31:0] x2, input logic [31:0] y2,
                                        input logic [31:0] x3, input logic [31:0] y3);
        return {x1, y1, x2, y2, x3, y3};
    endfunction

    always @(negedge clk) begin
        if (rst_n && rast_start) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_start xy=%h no triangle expected", rast_xy);
            end else begin
                e = exp_q.pop_front();
                if (rast_xy !== e.xy || rast_base !== e.base) begin
                    errors++;
                    $display("FAIL start_payload xy=%h base=%h required xy=%h base=%h",
                             rast_xy, rast_base, e.xy, e.base);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && t_rast_start) begin
            exp_t e;
            checks++;
            if (t_q.size() == 0) begin
                errors++;
                $display("FAIL t_unexpected_start xy=%h no triangle expected", t_rast_xy);
            end else begin
                e = t_q.pop_front();
                if (t_rast_xy !== e.xy || t_rast_base !== e.base) begin
                    errors++;
                    $display("FAIL t_start_payload xy=%h base=%h required xy=%h base=%h",
                             t_rast_xy, t_rast_base, e.xy, e.base);
                end
            end
        end
    end

    task automatic send(input bit sel, input logic [191:0] xy, input bit exp_go);
        int   n;
        exp_t e;
        n      = 0;
        e.xy   = xy;
        e.base = sel ? 26'd0 : m_base;
        @(negedge clk);
        if (sel) begin t_tri_valid = 1'b1; t_tri_xy = xy; end
        else     begin tri_valid   = 1'b1; tri_xy   = xy; end
        while (((sel ? t_tri_ready : tri_ready) !== 1'b1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ((sel ? t_tri_ready : tri_ready) !== 1'b1) begin
            errors++;
            $display("FAIL send_accept ready=0 required=1 after %0d cycles", n);
        end else begin
            @(posedge clk);
            if (exp_go) begin
                if (sel) t_q.push_back(e);
                else     exp_q.push_back(e);
            end
        end
        #1;
        if (sel) t_tri_valid = 1'b0;
        else     tri_valid   = 1'b0;
    endtask

    task automatic wait_start(input bit sel, input int max);
        int  n;
        bit  seen;
        seen = 1'b0;
        for (n = 0; n < max && !seen; n++) begin
            @(negedge clk);
            seen = sel ? t_rast_start : rast_start;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_start got=0 required=1 within %0d cycles", max);
        end
    endtask

    task automatic wait_idle(input bit sel, input int max);
        int n;
        n = 0;
        while ((sel ? t_busy : busy) !== 1'b0 && n < max) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ((sel ? t_busy : busy) !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle busy=1 required=0 within %0d cycles", max);
        end
    endtask

    task automatic pulse_done(input bit sel);
        @(negedge clk);
        if (sel) t_rast_done = 1'b1; else rast_done = 1'b1;
        @(negedge clk);
        if (sel) t_rast_done = 1'b0; else rast_done = 1'b0;
    endtask

    task automatic set_base(input logic [25:0] b);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_base = b;
        @(negedge clk);
        cfg_we   = 1'b0;
        m_base   = b;
    endtask

    task automatic test_reset;
        tri_valid = 0; tri_xy = '0; cfg_we = 0; cfg_base = '0; rast_done = 0;
        t_tri_valid = 0; t_tri_xy = '0; t_cfg_we = 0; t_cfg_base = '0; t_rast_done = 0;
        m_base = '0;
        #1 rst_n = 1'b0;
        #12;
        checks++;
        if (tri_ready !== 1'b1 || t_tri_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got=%b/%b required=1", tri_ready, t_tri_ready);
        end
        checks++;
        if ({busy, rast_start, timeout_err} !== 3'b000) begin
            errors++; $display("FAIL reset_flags busy/start/err=%b required=000", {busy, rast_start, timeout_err});
        end
        checks++;
        if (rast_xy !== '0 || rast_base !== '0 || tri_drawn !== '0 || tri_culled !== '0) begin
            errors++; $display("FAIL reset_regs xy=%h base=%h drawn=%0d culled=%0d required all 0",
                               rast_xy, rast_base, tri_drawn, tri_culled);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle busy=%b required=0", busy);
        end
    endtask

    task automatic test_cull;
        send(0, mk(5, 0, 5, 7, 5, 9), 0);
        repeat (8) @(negedge clk);
        checks++;
        if (tri_culled !== 16'd1 || tri_drawn !== 16'd0) begin
            errors++; $display("FAIL cull_counts culled=%0d drawn=%0d required 1/0", tri_culled, tri_drawn);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL cull_busy busy=%b required=0", busy);
        end
    endtask

    task automatic test_draw;
        logic [191:0] xy;
        logic [2:0]   seen;
        exp_t         e;
        set_base(26'h100);
        xy = mk(0, 0, 10, 0, 0, 10);
        e.xy = xy; e.base = 26'h100;
        @(negedge clk);
        tri_valid = 1'b1; tri_xy = xy;
        checks++;
        if (tri_ready !== 1'b1) begin
            errors++; $display("FAIL draw_ready got=%b required=1", tri_ready);
        end
        @(posedge clk);
        exp_q.push_back(e);
        #1 tri_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            seen[k] = rast_start;
        end
        checks++;
        if (seen !== 3'b100) begin
            errors++; $display("FAIL start_latency pattern=%b required=100", seen);
        end
        checks++;
        if (rast_xy !== xy || rast_base !== 26'h100) begin
            errors++; $display("FAIL draw_payload xy=%h base=%h required %h/100", rast_xy, rast_base, xy);
        end
        @(negedge clk);
        checks++;
        if (rast_start !== 1'b0) begin
            errors++; $display("FAIL start_width start=%b required=0", rast_start);
        end
        repeat (48) @(negedge clk);
        checks++;
        if (tri_drawn !== 16'd0 || busy !== 1'b1) begin
            errors++; $display("FAIL draw_waiting drawn=%0d busy=%b required 0/1", tri_drawn, busy);
        end
        pulse_done(0);
        repeat (2) @(negedge clk);
        checks++;
        if (tri_drawn !== 16'd1 || busy !== 1'b0) begin
            errors++; $display("FAIL draw_done drawn=%0d busy=%b required 1/0", tri_drawn, busy);
        end
    endtask

    task automatic test_cfg_base;
        send(0, mk(1, 2, 30, 4, 7, 40), 1);
        wait_start(0, 10);
        set_base(26'h200);
        repeat (3) @(negedge clk);
        checks++;
        if (rast_base !== 26'h100 || busy !== 1'b1) begin
            errors++; $display("FAIL base_hold base=%h busy=%b required 100/1", rast_base, busy);
        end
        pulse_done(0);
        wait_idle(0, 10);
        send(0, mk(3, 3, 9, 3, 3, 9), 1);
        wait_start(0, 10);
        checks++;
        if (rast_base !== 26'h200) begin
            errors++; $display("FAIL base_new base=%h required=200", rast_base);
        end
        pulse_done(0);
        wait_idle(0, 10);
        checks++;
        if (tri_drawn !== 16'd3) begin
            errors++; $display("FAIL cfg_drawn drawn=%0d required=3", tri_drawn);
        end
    endtask

    task automatic test_back_to_back;
        logic [191:0] items [6];
        exp_t         e;
        int           accepted;
        int           n;
        for (int i = 0; i < 6; i++) items[i] = mk(i, 0, i + 10, 0, i, i + 10);
        accepted  = 0;
        rast_done = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            tri_valid = 1'b1;
            tri_xy    = items[accepted];
            if (tri_ready === 1'b1) begin
                e.xy = items[accepted]; e.base = m_base;
                exp_q.push_back(e);
                accepted++;
            end
        end
        checks++;
        if (accepted != 5) begin
            errors++; $display("FAIL b2b_accepted got=%0d required=5", accepted);
        end
        checks++;
        if (tri_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_full ready=%b required=0", tri_ready);
        end
        rast_done = 1'b1;
        n = 0;
        while (accepted < 6 && n < 40) begin
            @(negedge clk);
            tri_xy = items[accepted];
            if (tri_ready === 1'b1) begin
                e.xy = items[accepted]; e.base = m_base;
                exp_q.push_back(e);
                accepted++;
            end
            n++;
        end
        @(posedge clk);
        #1 tri_valid = 1'b0;
        checks++;
        if (accepted != 6) begin
            errors++; $display("FAIL b2b_sixth got=%0d required=6", accepted);
        end
        wait_idle(0, 60);
        rast_done = 1'b0;
        checks++;
        if (tri_drawn !== 16'd9 || exp_q.size() != 0) begin
            errors++; $display("FAIL b2b_drain drawn=%0d pending=%0d required 9/0", tri_drawn, exp_q.size());
        end
    endtask

    task automatic test_timeout;
        int n;
        send(1, mk(0, 0, 20, 0, 0, 20), 1);
        send(1, mk(2, 2, 40, 2, 2, 40), 1);
        wait_start(1, 10);
        n = 0;
        for (int k = 1; k <= 40 && n == 0; k++) begin
            @(negedge clk);
            if (t_timeout_err === 1'b1) n = k;
        end
        checks++;
        if (n != 16) begin
            errors++; $display("FAIL timeout_delay got=%0d required=16 cycles after START", n);
        end
        checks++;
        if (t_tri_drawn !== 16'd0) begin
            errors++; $display("FAIL timeout_drawn drawn=%0d required=0", t_tri_drawn);
        end
        wait_start(1, 10);
        pulse_done(1);
        repeat (2) @(negedge clk);
        checks++;
        if (t_tri_drawn !== 16'd1 || t_timeout_err !== 1'b1 || t_busy !== 1'b0) begin
            errors++; $display("FAIL timeout_after drawn=%0d err=%b busy=%b required 1/1/0",
                               t_tri_drawn, t_timeout_err, t_busy);
        end
    endtask

    task automatic test_reset_mid_run;
        rast_done = 1'b0;
        send(0, mk(1, 1, 50, 1, 1, 50), 1);
        send(0, mk(2, 1, 50, 2, 1, 50), 1);
        send(0, mk(3, 1, 50, 3, 1, 50), 1);
        wait_start(0, 10);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        m_base = '0;
        #1;
        checks++;
        if (rast_xy !== '0 || rast_base !== '0 || rast_start !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL async_reset_out xy=%h base=%h start=%b busy=%b required 0",
                               rast_xy, rast_base, rast_start, busy);
        end
        checks++;
        if (tri_drawn !== '0 || tri_culled !== '0 || timeout_err !== 1'b0 || tri_ready !== 1'b1) begin
            errors++; $display("FAIL async_reset_cnt drawn=%0d culled=%0d err=%b ready=%b required 0/0/0/1",
                               tri_drawn, tri_culled, timeout_err, tri_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL flush_busy busy=%b required=0", busy);
        end
        send(0, mk(4, 4, 60, 4, 4, 60), 1);
        wait_start(0, 10);
        pulse_done(0);
        wait_idle(0, 10);
        checks++;
        if (tri_drawn !== 16'd1) begin
            errors++; $display("FAIL post_flush_drawn drawn=%0d required=1", tri_drawn);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_cull();
        test_draw();
        test_cfg_base();
        test_back_to_back();
        test_timeout();
        test_reset_mid_run();
        checks++;
        if (exp_q.size() != 0 || t_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_leftover pending=%0d/%0d required 0/0", exp_q.size(), t_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/raster_sched.md
RASTER_SCHED -- requirements
Module: raster_sched

Interface
REQ-001 Parameter DEPTH, default 4: triangle FIFO depth in entries; power of 2, at least 2.
REQ-002 Parameter TIMEOUT, default 1048576: watchdog limit in cycles while waiting for rasterizer completion.
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 tri_valid  in  1  upstream triangle command valid.
REQ-006 tri_ready  out  1  FIFO can accept a command.
REQ-007 tri_xy  in  192  packed {x1,y1,x2,y2,x3,y3}, 32 bits each, unsigned pixel coordinates.
REQ-008 cfg_we  in  1  write strobe for frame-buffer base.
REQ-009 cfg_base  in  26  frame-buffer base address.
REQ-010 rast_xy  out  192  vertices to rasterizer, same packing as tri_xy.
REQ-011 rast_base  out  26  frame-buffer base to rasterizer.
REQ-012 rast_start  out  1  one-cycle start pulse to rasterizer.
REQ-013 rast_done  in  1  rasterizer completion, level or pulse.
REQ-014 busy  out  1  work pending or in progress.
REQ-015 timeout_err  out  1  sticky watchdog error flag.
REQ-016 tri_drawn  out  16  count of completed triangles.
REQ-017 tri_culled  out  16  count of culled triangles.

Function
REQ-018 tri_ready SHALL equal !full, registered-count based; command accepted when tri_valid&tri_ready at a rising edge.
REQ-019 Push and pop in the same cycle SHALL leave the count unchanged; no push when full, even if a pop occurs that cycle.
REQ-020 FSM states SHALL be IDLE, CHECK, START, RUN.
REQ-021 IDLE with FIFO non-empty SHALL pop the head into rast_xy, latch the shadow base into rast_base, and go to CHECK.
REQ-022 CHECK: if x1==x2==x3 or y1==y2==y3 (degenerate), tri_culled SHALL increment and go to IDLE; else go to START.
REQ-023 START SHALL assert rast_start for exactly one cycle, clear the watchdog, and go to RUN.
REQ-024 RUN with rast_done=1 SHALL increment tri_drawn and go to IDLE.
REQ-025 RUN: watchdog SHALL increment each cycle; on reaching TIMEOUT-1 without rast_done, set timeout_err and go to IDLE, triangle dropped and not counted.
REQ-026 rast_done SHALL be ignored outside RUN, including during the START cycle.
REQ-027 Latency: for an empty, idle block, rast_start SHALL be high in the third cycle after the acceptance edge (accept at edge 0, CHECK after edge 1, START after edge 2).
REQ-028 rast_xy and rast_base SHALL hold stable from the IDLE->CHECK transition until the next IDLE->CHECK.
REQ-029 cfg_we SHALL update the shadow base register at any time; the new value applies from the next popped triangle only.
REQ-030 busy SHALL equal (state!=IDLE) | FIFO non-empty.
REQ-031 tri_drawn and tri_culled SHALL wrap modulo 2^16; timeout_err SHALL stay set until reset.

Reset
REQ-032 reset low SHALL immediately:
- force state IDLE
- empty the FIFO
- zero rast_xy, rast_base, shadow base, watchdog, counters, rast_start, timeout_err, busy
REQ-033 tri_ready SHALL read 1 while reset is asserted (FIFO empty).
REQ-034 After release, no rast_start SHALL occur until a new command is accepted.

Verification
REQ-035 Bench SHALL cover: push (0,0),(10,0),(0,10) with cfg_base 0x100, rast_done 50 cycles after start -> rast_start pulse in cycle 3, rast_xy matches input, rast_base=0x100, tri_drawn=1, busy=0 after completion.
REQ-036 Bench SHALL cover: push (5,0),(5,7),(5,9) -> no rast_start, tri_culled=1, tri_drawn=0.
REQ-037 Bench SHALL cover: DEPTH=4, rast_done held low, 6 back-to-back pushes -> exactly 5 accepted, tri_ready low, 6th held until a pop.
REQ-038 Bench SHALL cover: TIMEOUT=16, rast_done never asserted -> timeout_err set 16 cycles after the START cycle, then the next queued triangle starts normally.
REQ-039 Bench SHALL cover: reset asserted mid-RUN with 2 queued entries -> all outputs 0 asynchronously, FIFO flushed, no rast_start after release without a new push.
REQ-040 Bench SHALL cover: cfg_we with cfg_base 0x200 during RUN -> rast_base stays at the old value until the next triangle, then reads 0x200.
